// File: rtl/sa_pkg.sv
// Shared constants, index types and the ACC_W->OUT_W saturation helpers for the
// systolic-array result drain.
package sa_pkg;

    localparam int SA_N  = 4;
    localparam int ACC_W = 20;
    localparam int OUT_W = 16;
    localparam int IDX_W = $clog2(SA_N);

    typedef logic [IDX_W-1:0]   row_idx_t;
    // Element index inside a tile: {row, col}, row-major.
    typedef logic [2*IDX_W-1:0] tile_idx_t;

    localparam row_idx_t  ROW_LAST  = row_idx_t'(SA_N - 1);
    localparam tile_idx_t TILE_LAST = '1;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_e;

    // The value fits in OUT_W bits only if every bit above the OUT_W sign bit
    // matches that sign bit.
    function automatic logic sat_ovf(input logic [ACC_W-1:0] v);
        logic [ACC_W-OUT_W:0] top;
        top = v[ACC_W-1:OUT_W-1];
        return !((&top) || !(|top));
    endfunction

    function automatic logic [OUT_W-1:0] sat_clamp(input logic [ACC_W-1:0] v);
        if (!sat_ovf(v)) begin
            return v[OUT_W-1:0];
        end
        return v[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/sa_sat.sv
// Combinational signed clamp of one accumulator to the output width, with a
// flag telling whether the value had to be clamped.
module sa_sat
    import sa_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] data_o,
    output logic             ovf_o
);

    assign data_o = sat_clamp(acc_i);
    assign ovf_o  = sat_ovf(acc_i);

endmodule

// File: rtl/sa_result_drain.sv
// Captures PE result rows into a ping-pong tile buffer and streams each tile
// out one saturated element per beat, row-major, over valid/ready.
module sa_result_drain
    import sa_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SA_N*ACC_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [IDX_W-1:0]      out_row,
    output logic [IDX_W-1:0]      out_col,
    output logic                  out_last,
    output logic                  sat_seen,
    input  logic                  sat_clr
);

    logic [ACC_W-1:0] mem_q [2][SA_N][SA_N];
    logic [1:0]       full_q, full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    row_idx_t         beat_q, beat_d;
    tile_idx_t        elem_q, elem_d;
    logic             in_ready_q, in_ready_d;
    logic             sat_seen_q, sat_seen_d;
    rd_state_e        state_q, state_d;

    logic             wr_fire, wr_done, rd_fire, rd_done;
    row_idx_t         wr_row;
    logic [OUT_W-1:0] sat_data;
    logic             sat_hit;

    assign wr_fire = in_valid && in_ready_q;
    assign wr_done = wr_fire && (beat_q == ROW_LAST);
    assign rd_fire = out_valid && out_ready;
    assign rd_done = rd_fire && (elem_q == TILE_LAST);
    // Bottom array row leaves the array first.
    assign wr_row  = ROW_LAST - beat_q;

    assign out_row = elem_q[2*IDX_W-1:IDX_W];
    assign out_col = elem_q[IDX_W-1:0];

    sa_sat u_sat (
        .acc_i  (mem_q[rd_sel_q][out_row][out_col]),
        .data_o (sat_data),
        .ovf_o  (sat_hit)
    );

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if-chain can leave a latch behind.
    always_comb begin
        full_d     = full_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        beat_d     = beat_q;
        elem_d     = elem_q;
        if (wr_fire) begin
            beat_d = wr_done ? '0 : beat_q + 1'b1;
        end
        if (wr_done) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (rd_fire) begin
            elem_d = rd_done ? '0 : elem_q + 1'b1;
        end
        // The in_ready gate keeps the write bank and the read bank distinct.
        if (rd_done) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
        in_ready_d = !full_d[wr_sel_d];
        sat_seen_d = sat_clr ? 1'b0 : (sat_seen_q || (rd_fire && sat_hit));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q     <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            beat_q     <= '0;
            elem_q     <= '0;
            in_ready_q <= 1'b1;
            sat_seen_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            beat_q     <= beat_d;
            elem_q     <= elem_d;
            in_ready_q <= in_ready_d;
            sat_seen_q <= sat_seen_d;
        end
    end

    // NOTE: tile storage has no reset; the full flags decide whether its
    // contents are ever read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int j = 0; j < SA_N; j++) begin
                mem_q[wr_sel_q][wr_row][j] <= in_data[j*ACC_W +: ACC_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Looking at full_d gives zero-bubble starts, including a tile whose last
    // beat lands in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:   if (full_d[rd_sel_q]) state_d = RD_STREAM;
            RD_STREAM: if (rd_done)          state_d = full_d[rd_sel_d] ? RD_STREAM : RD_IDLE;
            default:                         state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == RD_STREAM);
        out_last  = out_valid && (elem_q == TILE_LAST);
        out_data  = out_valid ? sat_data : '0;
    end

    assign in_ready = in_ready_q;
    assign sat_seen = sat_seen_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Randomized scoreboard bench for sa_result_drain: the driver pushes expected
// elements per accepted tile, a negedge monitor pops and compares.
module tb_sa_result_drain;
    import sa_pkg::*;

    localparam int N = SA_N;
    typedef int tile_t [N][N];
    typedef struct {
        int data;
        int row;
        int col;
        bit last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  in_valid;
    logic                  in_ready;
    logic [SA_N*ACC_W-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic [IDX_W-1:0]      out_row;
    logic [IDX_W-1:0]      out_col;
    logic                  out_last;
    logic                  sat_seen;
    logic                  sat_clr;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   ready_mode = 1;

    sa_result_drain dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .sat_seen  (sat_seen),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_ref(input int v);
        int hi = (1 << (OUT_W - 1)) - 1;
        int lo = -(1 << (OUT_W - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic push_tile(input tile_t t);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                sb.push_back('{data: clamp_ref(t[r][c]), row: r, col: c,
                               last: (r == N - 1) && (c == N - 1)});
            end
        end
    endtask

    task automatic drive_row(input tile_t t, input int k);
        for (int j = 0; j < N; j++) begin
            in_data[j*ACC_W +: ACC_W] = t[N-1-k][j][ACC_W-1:0];
        end
    endtask

    // Sends beats first..last of a tile; expectations are pushed once the
    // final beat has been accepted.
    task automatic send_rows(input tile_t t, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            bit acc = 1'b0;
            in_valid = 1'b1;
            drive_row(t, k);
            for (int w = 0; w < 300 && !acc; w++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
            end
            check("beat_accepted", int'(acc), 1);
        end
        in_valid = 1'b0;
        if (last == N - 1) push_tile(t);
    endtask

    task automatic send_tile(input tile_t t);
        send_rows(t, 0, N - 1);
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 3000 && (sb.size() != 0 || out_valid); w++) begin
            @(posedge clk);
            #1;
        end
        check("drain_done", sb.size(), 0);
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        in_valid = 1'b0;
        sat_clr  = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_row", int'(out_row), 0);
        check("rst_out_col", int'(out_col), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_sat_seen", int'(sat_seen), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    function automatic tile_t pattern_tile(input int base);
        tile_t t;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                t[r][c] = base + 10 * r + c;
        return t;
    endfunction

    function automatic tile_t random_tile();
        tile_t t;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 1) == 0)
                    t[r][c] = int'($urandom_range(0, 80000)) - 40000;
                else
                    t[r][c] = int'($urandom_range(0, (1 << ACC_W) - 1)) - (1 << (ACC_W - 1));
            end
        end
        return t;
    endfunction

    // out_ready driver: 0 = held low, 1 = held high, otherwise random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: ordering, stall stability, and valid whenever a tile is pending.
    exp_t held;
    bit   held_v = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            held_v = 1'b0;
        end else begin
            check("valid_vs_pending", int'(out_valid), int'(sb.size() != 0));
            if (held_v && out_valid) begin
                check("stall_data", int'($signed(out_data)), held.data);
                check("stall_row", int'(out_row), held.row);
                check("stall_col", int'(out_col), held.col);
                check("stall_last", int'(out_last), int'(held.last));
            end
            if (out_valid && out_ready) begin
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", int'($signed(out_data)), e.data);
                    check("out_row", int'(out_row), e.row);
                    check("out_col", int'(out_col), e.col);
                    check("out_last", int'(out_last), int'(e.last));
                end
                held_v = 1'b0;
            end else if (out_valid) begin
                held   = '{data: int'($signed(out_data)), row: int'(out_row),
                          col: int'(out_col), last: out_last};
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        tile_t ta, tb_t, tc;
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sat_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single pattern tile, consumer always ready.
        ready_mode = 1;
        send_tile(pattern_tile(0));
        wait_drain();
        check("no_sat_seen", int'(sat_seen), 0);

        // Two tiles with the consumer blocked fill both banks.
        ready_mode = 0;
        send_tile(pattern_tile(100));
        send_tile(pattern_tile(200));
        @(negedge clk);
        check("in_ready_both_full", int'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = '1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("in_ready_blocked", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        in_valid   = 1'b0;
        ready_mode = 1;
        wait_drain();

        // Saturation at and beyond both limits.
        ta = pattern_tile(0);
        ta[0][0] = 40000;
        ta[1][2] = -40000;
        ta[2][1] = 32767;
        ta[2][2] = 32768;
        ta[3][0] = -32768;
        ta[3][3] = -32769;
        send_tile(ta);
        wait_drain();
        check("sat_seen_set", int'(sat_seen), 1);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        @(negedge clk);
        check("sat_seen_cleared", int'(sat_seen), 0);
        @(posedge clk);
        #1;

        // Random data with random consumer back-pressure.
        ready_mode = 2;
        for (int i = 0; i < 8; i++) send_tile(random_tile());
        wait_drain();
        ready_mode = 1;

        // Reset after two input beats, then mid-stream.
        send_rows(pattern_tile(300), 0, 1);
        do_reset();
        ready_mode = 0;
        send_tile(pattern_tile(400));
        repeat (3) @(posedge clk);
        #1;
        ready_mode = 1;
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        send_tile(random_tile());
        wait_drain();

        // Final read handshake of one bank coincides with the last write beat
        // of the other bank.
        ready_mode = 0;
        ta   = pattern_tile(500);
        tb_t = random_tile();
        tc   = random_tile();
        send_tile(ta);
        send_rows(tb_t, 0, N - 2);
        ready_mode = 1;
        repeat (N * N - 1) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        drive_row(tb_t, N - 1);
        @(negedge clk);
        check("coincide_in_ready", int'(in_ready), 1);
        check("coincide_out_last", int'(out_last && out_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        push_tile(tb_t);
        send_tile(tc);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
